// File: rtl/cc_pkg.sv
// Shared types and defaults for the cache controller FIFO readers.
// Holds the read-engine state encoding and default widths.
package cc_pkg;

    localparam int CC_DATA_WIDTH = 32;
    localparam int CC_LEN_WIDTH  = 4;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } cc_rd_state_t;

endpackage

// File: rtl/cc_skid_buf.sv
// Two-entry in-order registered buffer, valid/ready on both sides.
// Ports: in_valid/in_data/not_full (write), out_valid/out_data/out_ready (read).
module cc_skid_buf
    import cc_pkg::*;
#(
    parameter int W = CC_DATA_WIDTH + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         not_full,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   count_q;
    logic         push;
    logic         pop;

    assign not_full  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid & not_full;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            unique case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= in_data;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    unique case ({push, pop})
                        // push and pop together: head is replaced, count stays 1
                        2'b11: head_q <= in_data;
                        2'b10: begin
                            tail_q  <= in_data;
                            count_q <= 2'd2;
                        end
                        2'b01: count_q <= 2'd0;
                        default: ;
                    endcase
                end
                2'd2: begin
                    // full: no push possible, drain tail into head
                    if (pop) begin
                        head_q  <= tail_q;
                        count_q <= 2'd1;
                    end
                end
                default: count_q <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/cc_fifo_burst_reader.sv
// Burst read engine: pops req_len_i+1 words from a show-ahead FIFO onto a stream.
// Ports: req_* (burst request), fifo_* (FIFO read side), out_* (beat stream), busy_o.
module cc_fifo_burst_reader
    import cc_pkg::*;
#(
    parameter int DATA_WIDTH = CC_DATA_WIDTH,
    parameter int LEN_WIDTH  = CC_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [LEN_WIDTH-1:0]  req_len_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rden_o,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o
);

    cc_rd_state_t         state_q;
    cc_rd_state_t         state_d;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cnt_q;
    logic                 req_fire;
    logic                 pop_last;
    logic                 buf_not_full;
    logic                 buf_valid;
    logic [DATA_WIDTH:0]  buf_data;

    assign req_ready_o = (state_q == S_IDLE);
    assign req_fire    = req_valid_i & req_ready_o;
    assign pop_last    = (cnt_q == len_q);
    assign fifo_rden_o = (state_q == S_BURST) & ~fifo_empty_i & buf_not_full;
    assign busy_o      = (state_q == S_BURST) | buf_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (state_q == S_IDLE): begin
                if (req_fire) state_d = S_BURST;
            end
            (state_q == S_BURST): begin
                if (fifo_rden_o && pop_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q <= '0;
            cnt_q <= '0;
        end else if (req_fire) begin
            len_q <= req_len_i;
            cnt_q <= '0;
        end else if (fifo_rden_o) begin
            // the final pop leaves the burst, so a wrap here is never observed
            cnt_q <= cnt_q + 1'b1;
        end
    end

    cc_skid_buf #(
        .W(DATA_WIDTH + 1)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (fifo_rden_o),
        .in_data  ({fifo_rdata_i, pop_last}),
        .not_full (buf_not_full),
        .out_valid(buf_valid),
        .out_data (buf_data),
        .out_ready(out_ready_i)
    );

    assign out_valid_o = buf_valid;
    assign out_data_o  = buf_data[DATA_WIDTH:1];
    assign out_last_o  = buf_data[0];

endmodule

// File: tb/tb_cc_fifo_burst_reader.sv
// Scoreboard bench for cc_fifo_burst_reader with a queue-based FIFO/stream model.
// Directed scenarios followed by randomized bursts, ready and starvation.
module tb_cc_fifo_burst_reader;

    localparam int DW = 32;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [LW-1:0] req_len = '0;
    logic          fifo_empty;
    logic          fifo_rden;
    logic [DW-1:0] fifo_rdata;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    cc_fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_len_i   (req_len),
        .fifo_empty_i(fifo_empty),
        .fifo_rden_o (fifo_rden),
        .fifo_rdata_i(fifo_rdata),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .busy_o      (busy)
    );

    // show-ahead FIFO model
    logic [DW-1:0] mem [0:255];
    int            rd_ptr = 0;
    int            wr_ptr = 0;
    logic          starve = 1'b0;
    logic          flush = 1'b0;

    assign fifo_empty = (rd_ptr == wr_ptr) || starve;
    assign fifo_rdata = mem[rd_ptr[7:0]];

    int            checks = 0;
    int            failures = 0;
    logic [DW:0]   sb[$];
    logic [DW-1:0] words[$];
    int            rem = 0;
    int            outst = 0;
    int            cyc = 0;
    int            pops = 0;
    int            acc_cyc[$];
    int            pop_cyc[$];
    int            beat_cyc[$];
    bit            started = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // reference model: burst bookkeeping in terms of beats owed and held
    always @(posedge clk) begin
        cyc++;
        if (flush) rd_ptr <= wr_ptr;
        else if (fifo_rden) rd_ptr <= rd_ptr + 1;
        if (!rst_n) begin
            rem = 0;
            outst = 0;
            sb.delete();
            started = 1;
        end else begin
            if (fifo_rden) begin
                pops++;
                pop_cyc.push_back(cyc);
                rem--;
                outst++;
            end
            if (out_valid && out_ready) outst--;
            if (req_valid && req_ready) begin
                rem = int'(req_len) + 1;
                acc_cyc.push_back(cyc);
            end
        end
    end

    // monitor
    logic          pv = 1'b0;
    logic [DW-1:0] pd = '0;
    logic          pl = 1'b0;

    always @(negedge clk) begin
        logic [DW:0] e;
        if (started) begin
            chk("req_ready", 64'(req_ready), 64'(rem == 0));
            chk("busy", 64'(busy), 64'((rem != 0) || (outst != 0)));
            chk("out_valid", 64'(out_valid), 64'(outst != 0));
            if (fifo_empty) chk("rden_when_empty", 64'(fifo_rden), 64'd0);
            if (outst >= 2) chk("rden_when_full", 64'(fifo_rden), 64'd0);
            if (pv) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(pd));
                chk("stall_last", 64'(out_last), 64'(pl));
            end
            if (out_valid && out_ready) begin
                beat_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h expected=none",
                             out_data);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", 64'(out_data), 64'(e[DW:1]));
                    chk("beat_last", 64'(out_last), 64'(e[0]));
                end
            end
            pv = out_valid && !out_ready && rst_n;
            pd = out_data;
            pl = out_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int n, input logic [DW-1:0] base, input bit rnd);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd ? DW'($urandom) : base + DW'(i);
            mem[wr_ptr[7:0]] = w;
            wr_ptr++;
            words.push_back(w);
        end
    endtask

    task automatic issue(input int len);
        int n;
        int a0;
        for (int i = 0; i <= len; i++) sb.push_back({words.pop_front(), i == len});
        a0 = acc_cyc.size();
        req_len = LW'(len);
        req_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (acc_cyc.size() == a0 && n < 100);
        if (acc_cyc.size() == a0) begin
            checks++;
            failures++;
            $display("FAIL req_accept_timeout actual=%0d expected=accepted", n);
        end
        req_valid = 1'b0;
        req_len = LW'($urandom);
    endtask

    // mode 0: ready=1, 1: ready alternates 1,0,.., 2: random ready and starve
    task automatic drain(input int mode);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 400) begin
            unique case (mode)
                1: out_ready = (n % 2 == 0);
                2: begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    starve = ($urandom_range(0, 4) == 0);
                end
                default: out_ready = 1'b1;
            endcase
            step();
            n++;
        end
        starve = 1'b0;
        out_ready = 1'b1;
        if (n >= 400) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d expected=%0d", sb.size(), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int a;
        int n;
        int b0;

        // 1: reset
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rst_req_ready", 64'(req_ready), 64'd1);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_rden", 64'(fifo_rden), 64'd0);
            chk("rst_out_data", 64'(out_data), 64'd0);
            chk("rst_out_last", 64'(out_last), 64'd0);
            step();
        end

        // 2: 4-beat burst at full rate
        out_ready = 1'b1;
        load(4, 32'hA0, 0);
        base = pops;
        b0 = beat_cyc.size();
        issue(3);
        a = acc_cyc[$];
        drain(0);
        chk("t2_pops", 64'(pops - base), 64'd4);
        chk("t2_beats", 64'(beat_cyc.size() - b0), 64'd4);
        if (beat_cyc.size() - b0 == 4) begin
            for (int i = 0; i < 4; i++)
                chk("t2_beat_cycle", 64'(beat_cyc[b0 + i]), 64'(a + 1 + i));
        end

        // 3: 8 beats with alternating ready
        load(8, 32'hB0, 0);
        out_ready = 1'b1;
        b0 = beat_cyc.size();
        issue(7);
        drain(1);
        chk("t3_beats", 64'(beat_cyc.size() - b0), 64'd8);

        // 4: starvation after the second pop
        load(5, 32'hC0, 0);
        base = pops;
        issue(4);
        n = 0;
        while (pops - base < 2 && n < 50) begin
            step();
            n++;
        end
        starve = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_no_pop_starved", 64'(pops - base), 64'd2);
        end
        starve = 1'b0;
        drain(0);
        chk("t4_pops", 64'(pops - base), 64'd5);

        // 5: back-to-back single-beat requests
        load(2, 32'hD0, 0);
        issue(0);
        issue(0);
        chk("t5_accept_after_pop", 64'(acc_cyc[$]), 64'(pop_cyc[$] + 1));
        drain(0);

        // 6: reset mid-burst
        load(8, 32'hE0, 0);
        base = pops;
        b0 = beat_cyc.size();
        issue(7);
        n = 0;
        while (pops - base < 2 && n < 50) begin
            step();
            n++;
        end
        starve = 1'b1;
        n = 0;
        while (beat_cyc.size() - b0 < 2 && n < 50) begin
            step();
            n++;
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        starve = 1'b0;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_req_ready", 64'(req_ready), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++) step();
        chk("t6_words_left", 64'(wr_ptr - rd_ptr), 64'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        words.delete();

        // randomized bursts
        for (int k = 0; k < 30; k++) begin
            n = $urandom_range(0, 15);
            load(n + 1, '0, 1);
            base = pops;
            out_ready = $urandom_range(0, 1);
            issue(n);
            drain(2);
            chk("rand_pops", 64'(pops - base), 64'(n + 1));
        end

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
